data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Sits between the memory stage and the on-chip data SRAM. Accepts one load/store per request.
//  Aligns store data and byte masks to 64-bit SRAM words and returns load data right-aligned.
//  The memory stage sign/zero-extends that load data. Any access crossing a word boundary is
//  split into two SRAM accesses. The pipeline is held with stall_o while an access is in flight.
// PARAMETERS
//  MEM_BYTES  524288           data memory size in bytes (power of 2, multiple of 8)
//  WORD_AW    $clog2(MEM_BYTES/8)  SRAM word-address width (derived, not overridden)
// PORTS
//  clk           in   1        clock, rising edge
//  reset_n       in   1        reset, asynchronous, active-low
//  req_i         in   1        access request; held stable with all request inputs while stall_o=1
//  addr_i        in   64       byte address
//  byte_en_i     in   2        size: 00 byte, 01 half, 10 word, 11 double
//  wr_i          in   1        1=store, 0=load
//  wr_data_i     in   64       store data, right-aligned
//  stall_o       out  1        hold pipeline
//  rd_data_o     out  64       load data, right-aligned, unextended (to memory stage mem_rd_data_i)
//  rd_valid_o    out  1        rd_data_o valid (loads only), 1-cycle pulse
//  addr_err_o    out  1        out-of-range access, 1-cycle pulse
//  sram_en_o     out  1        SRAM access enable
//  sram_we_o     out  1        SRAM write
//  sram_be_o     out  8        SRAM byte write mask
//  sram_addr_o   out  WORD_AW  SRAM word address
//  sram_wdata_o  out  64       SRAM write data
//  sram_rdata_i  in   64       SRAM read data, valid the cycle after sram_en_o with sram_we_o=0
// BEHAVIOUR
//  Derived values:
//   off=addr_i[2:0]; N=1/2/4/8 bytes; m=(2^N-1)<<off, 16 bits; d=wr_data_i<<(8*off), 128 bits.
//   split = off+N > 8; w0 = addr_i[WORD_AW+2:3]; w1 = w0+1.
//  Error condition err: addr_i >= MEM_BYTES, or split with w0 = last word. Word addresses never wrap.
//  FSM states: IDLE, WAIT0, WAIT1, ERR. Only IDLE samples req_i.
//  IDLE, req_i=1, err=0:
//   - Latch the request. Drive SRAM combinationally this cycle:
//     en=1, we=wr_i, addr=w0, be=m[7:0] (0 for loads), wdata=d[63:0].
//   - stall_o=1. Next state WAIT0.
//  IDLE, req_i=1, err=1:
//   - No SRAM access. stall_o=1. Next state ERR.
//  ERR:
//   - addr_err_o=1, rd_data_o=0, rd_valid_o=0, stall_o=0. Next state IDLE.
//  WAIT0, not split:
//   - Load: rd_data_o = (sram_rdata_i>>8*off), masked to N bytes; rd_valid_o=1.
//   - stall_o=0. Next state IDLE.
//  WAIT0, split:
//   - Capture sram_rdata_i>>8*off into a low buffer.
//   - Issue the second access: addr=w1, be=m[15:8], wdata=d[127:64].
//   - stall_o=1. Next state WAIT1.
//  WAIT1:
//   - Load: rd_data_o = buffer | (sram_rdata_i << 8*(8-off)), masked to N bytes; rd_valid_o=1.
//   - stall_o=0. Next state IDLE.
//  Latency:
//   - Aligned access: 1 stall cycle. Split access: 2 stall cycles. Error: 1 stall cycle.
//   - The pipeline advances at the edge closing the completion cycle. The next request is
//     sampled in IDLE on the following cycle, so back-to-back requests cost no extra bubble.
//  Outputs:
//   - rd_data_o is 0 whenever rd_valid_o=0.
//   - Stores never assert rd_valid_o.
//   - sram_* outputs are 0 when sram_en_o=0.
//  Reset (reset_n=0, any time, including mid-split):
//   - State to IDLE immediately; all outputs 0; buffer cleared.
//   - A split store interrupted after its first access leaves word w0 written. No rollback.
//  req_i=0 in IDLE: no SRAM access, stall_o=0.
// TESTING
//  1 SD 0x1122334455667788 @0x10, then LD @0x10:
//    rd_data_o=0x1122334455667788, rd_valid_o 1 cycle after acceptance, 1 stall cycle.
//  2 After test 1, LB @0x13 -> rd_data_o=0x55; LH @0x16 -> 0x1122; sram_be_o=0 on loads.
//  3 SW 0xAABBCCDD @0x1E:
//    -> word 0x3 be=0xC0, wdata[63:48]=0xCCDD; word 0x4 be=0x03, wdata[15:0]=0xAABB.
//    Then LW @0x1E -> 0xAABBCCDD after 2 stall cycles.
//  4 LD @0x80000 -> no sram_en_o, addr_err_o=1 on the cycle after request, stall 1 cycle, rd_valid_o=0.
//  5 LD @0x7FFF9 (split on last word) -> addr_err_o pulse, no SRAM access; LB @0x7FFFF succeeds.
//  6 Split LD in progress, reset_n=0 during WAIT1:
//    stall_o/rd_valid_o/sram_en_o drop to 0 asynchronously; after release FSM accepts a new request in IDLE.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - load/store controller aligning pipeline accesses to a 64-bit data SRAM
module data_mem_ctrl #(
  parameter  int MEM_BYTES = 524288,
  localparam int WORD_AW   = $clog2(MEM_BYTES / 8)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_i,
  input  logic [63:0]        addr_i,
  input  logic [1:0]         byte_en_i,
  input  logic               wr_i,
  input  logic [63:0]        wr_data_i,
  output logic               stall_o,
  output logic [63:0]        rd_data_o,
  output logic               rd_valid_o,
  output logic               addr_err_o,
  output logic               sram_en_o,
  output logic               sram_we_o,
  output logic [7:0]         sram_be_o,
  output logic [WORD_AW-1:0] sram_addr_o,
  output logic [63:0]        sram_wdata_o,
  input  logic [63:0]        sram_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT0 = 2'd1,
    S_WAIT1 = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // Request fields held for the whole access (the second half of a split needs them)
  logic [2:0]         r_off;
  logic [1:0]         r_size;
  logic               r_wr;
  logic               r_split;
  logic [WORD_AW-1:0] r_w1;
  logic [7:0]         r_be_hi;
  logic [63:0]        r_wd_hi;
  logic [63:0]        r_buf;

  // Values derived from the live request inputs (only meaningful in IDLE)
  logic [2:0]         w_off;
  logic [3:0]         w_nbytes;
  logic [7:0]         w_bmask;
  logic [15:0]        w_m;
  logic [127:0]       w_d;
  logic               w_split;
  logic [WORD_AW-1:0] w_w0;
  logic [WORD_AW-1:0] w_w1;
  logic               w_err;

  // Read-return helpers based on the latched request
  logic [63:0]        w_rd_mask;
  logic [63:0]        w_rd_lo;
  logic [63:0]        w_rd_hi;

  assign w_off   = addr_i[2:0];
  assign w_m     = {8'h00, w_bmask} << w_off;
  assign w_d     = {64'h0, wr_data_i} << {w_off, 3'b000};
  assign w_split = ({1'b0, w_off} + w_nbytes) > 4'd8;
  assign w_w0    = addr_i[WORD_AW+2:3];
  assign w_w1    = w_w0 + {{(WORD_AW-1){1'b0}}, 1'b1};
  // A split touching the last word would need a word past the end; addresses never wrap.
  assign w_err   = (addr_i >= 64'(MEM_BYTES)) || (w_split && (&w_w0));

  assign w_rd_lo = sram_rdata_i >> {r_off, 3'b000};
  // Upper part of a split load lands just above the bytes taken from the first word.
  assign w_rd_hi = sram_rdata_i << {(4'd8 - {1'b0, r_off}), 3'b000};

  // Decode access size into byte count and base byte mask
  always_comb begin
    w_nbytes = 4'd1;
    w_bmask  = 8'h01;
    case (byte_en_i)
      2'b00: begin w_nbytes = 4'd1; w_bmask = 8'h01; end
      2'b01: begin w_nbytes = 4'd2; w_bmask = 8'h03; end
      2'b10: begin w_nbytes = 4'd4; w_bmask = 8'h0F; end
      default: begin w_nbytes = 4'd8; w_bmask = 8'hFF; end
    endcase
  end

  // Load result mask for the latched access size
  always_comb begin
    w_rd_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    case (r_size)
      2'b00: w_rd_mask = 64'h0000_0000_0000_00FF;
      2'b01: w_rd_mask = 64'h0000_0000_0000_FFFF;
      2'b10: w_rd_mask = 64'h0000_0000_FFFF_FFFF;
      default: w_rd_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Latch an accepted request and buffer the low part of a split load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_off   <= 3'd0;
      r_size  <= 2'd0;
      r_wr    <= 1'b0;
      r_split <= 1'b0;
      r_w1    <= '0;
      r_be_hi <= 8'h00;
      r_wd_hi <= 64'h0;
      r_buf   <= 64'h0;
    end else begin
      if ((r_state == S_IDLE) && req_i && !w_err) begin
        r_off   <= w_off;
        r_size  <= byte_en_i;
        r_wr    <= wr_i;
        r_split <= w_split;
        r_w1    <= w_w1;
        r_be_hi <= w_m[15:8];
        r_wd_hi <= w_d[127:64];
      end
      if ((r_state == S_WAIT0) && r_split) begin
        r_buf <= w_rd_lo;
      end
    end
  end

  // Next state and all outputs; everything forced low while reset is held
  always_comb begin
    w_next       = r_state;
    stall_o      = 1'b0;
    rd_data_o    = 64'h0;
    rd_valid_o   = 1'b0;
    addr_err_o   = 1'b0;
    sram_en_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_be_o    = 8'h00;
    sram_addr_o  = '0;
    sram_wdata_o = 64'h0;
    if (reset_n) begin
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            stall_o = 1'b1;
            if (w_err) begin
              w_next = S_ERR;
            end else begin
              w_next       = S_WAIT0;
              sram_en_o    = 1'b1;
              sram_we_o    = wr_i;
              sram_addr_o  = w_w0;
              sram_be_o    = wr_i ? w_m[7:0] : 8'h00;
              sram_wdata_o = w_d[63:0];
            end
          end
        end
        S_WAIT0: begin
          if (r_split) begin
            w_next       = S_WAIT1;
            stall_o      = 1'b1;
            sram_en_o    = 1'b1;
            sram_we_o    = r_wr;
            sram_addr_o  = r_w1;
            sram_be_o    = r_wr ? r_be_hi : 8'h00;
            sram_wdata_o = r_wd_hi;
          end else begin
            w_next = S_IDLE;
            if (!r_wr) begin
              rd_data_o  = w_rd_lo & w_rd_mask;
              rd_valid_o = 1'b1;
            end
          end
        end
        S_WAIT1: begin
          w_next = S_IDLE;
          if (!r_wr) begin
            rd_data_o  = (r_buf | w_rd_hi) & w_rd_mask;
            rd_valid_o = 1'b1;
          end
        end
        default: begin
          w_next     = S_IDLE;
          addr_err_o = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;

  logic        clk;
  logic        reset_n;
  logic        req_i;
  logic [63:0] addr_i;
  logic [1:0]  byte_en_i;
  logic        wr_i;
  logic [63:0] wr_data_i;
  logic        stall_o;
  logic [63:0] rd_data_o;
  logic        rd_valid_o;
  logic        addr_err_o;
  logic        sram_en_o;
  logic        sram_we_o;
  logic [7:0]  sram_be_o;
  logic [15:0] sram_addr_o;
  logic [63:0] sram_wdata_o;
  logic [63:0] sram_rdata_i;

  data_mem_ctrl #(.MEM_BYTES(524288)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_i        (req_i),
    .addr_i       (addr_i),
    .byte_en_i    (byte_en_i),
    .wr_i         (wr_i),
    .wr_data_i    (wr_data_i),
    .stall_o      (stall_o),
    .rd_data_o    (rd_data_o),
    .rd_valid_o   (rd_valid_o),
    .addr_err_o   (addr_err_o),
    .sram_en_o    (sram_en_o),
    .sram_we_o    (sram_we_o),
    .sram_be_o    (sram_be_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_rdata_i (sram_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: byte-masked writes, registered read data
  logic [63:0] mem [0:65535];
  always @(posedge clk) begin
    if (sram_en_o) begin
      if (sram_we_o) begin
        for (int b = 0; b < 8; b++)
          if (sram_be_o[b]) mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
      end else begin
        sram_rdata_i <= mem[sram_addr_o];
      end
    end
  end

  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Observations of one access
  int          n_stall;
  int          n_acc;
  logic [15:0] acc_addr [0:3];
  logic [7:0]  acc_be   [0:3];
  logic [63:0] acc_wd   [0:3];
  logic        acc_we   [0:3];
  logic        got_valid;
  int          valid_cyc;
  logic [63:0] rdat;
  logic        err_seen;
  int          err_cyc;
  int          stray;

  // Issue one request at posedge+1 and watch it until stall_o drops
  task automatic access(input logic [63:0] a, input logic [1:0] sz, input logic w, input logic [63:0] wd);
    logic done;
    done      = 1'b0;
    n_stall   = 0;
    n_acc     = 0;
    got_valid = 1'b0;
    valid_cyc = -1;
    rdat      = 64'h0;
    err_seen  = 1'b0;
    err_cyc   = -1;
    req_i     = 1'b1;
    addr_i    = a;
    byte_en_i = sz;
    wr_i      = w;
    wr_data_i = wd;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (sram_en_o && n_acc < 4) begin
        acc_addr[n_acc] = sram_addr_o;
        acc_be[n_acc]   = sram_be_o;
        acc_wd[n_acc]   = sram_wdata_o;
        acc_we[n_acc]   = sram_we_o;
        n_acc++;
      end
      if (!sram_en_o && (sram_we_o || sram_be_o != 0 || sram_addr_o != 0 || sram_wdata_o != 0)) stray++;
      if (!rd_valid_o && rd_data_o != 0) stray++;
      if (rd_valid_o) begin got_valid = 1'b1; valid_cyc = c; rdat = rd_data_o; end
      if (addr_err_o) begin err_seen = 1'b1; err_cyc = c; end
      if (stall_o) n_stall++;
      else done = 1'b1;
      @(posedge clk);
      #1;
      if (done) break;
    end
    req_i = 1'b0;
    check("access_done", {63'h0, done}, 64'h1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    stray    = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 64'h0;
    sram_rdata_i = 64'h0;
    reset_n   = 1'b0;
    req_i     = 1'b0;
    addr_i    = 64'h0;
    byte_en_i = 2'b00;
    wr_i      = 1'b0;
    wr_data_i = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", {63'h0, stall_o}, 64'h0);
    check("rst_en", {63'h0, sram_en_o}, 64'h0);
    check("rst_valid", {63'h0, rd_valid_o}, 64'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("idle_stall", {63'h0, stall_o}, 64'h0);
    check("idle_en", {63'h0, sram_en_o}, 64'h0);
    @(posedge clk);
    #1;

    // 1: SD then LD at 0x10
    access(64'h10, 2'b11, 1'b1, 64'h1122334455667788);
    check("sd_nacc", n_acc, 1);
    check("sd_addr", acc_addr[0], 64'h2);
    check("sd_be", acc_be[0], 64'hFF);
    check("sd_we", {63'h0, acc_we[0]}, 64'h1);
    check("sd_wdata", acc_wd[0], 64'h1122334455667788);
    check("sd_stall", n_stall, 1);
    check("sd_novalid", {63'h0, got_valid}, 64'h0);
    access(64'h10, 2'b11, 1'b0, 64'h0);
    check("ld_data", rdat, 64'h1122334455667788);
    check("ld_vcyc", valid_cyc, 1);
    check("ld_stall", n_stall, 1);
    check("ld_be", acc_be[0], 64'h0);
    check("ld_we", {63'h0, acc_we[0]}, 64'h0);

    // 2: sub-word loads
    access(64'h13, 2'b00, 1'b0, 64'h0);
    check("lb_data", rdat, 64'h55);
    check("lb_be", acc_be[0], 64'h0);
    access(64'h16, 2'b01, 1'b0, 64'h0);
    check("lh_data", rdat, 64'h1122);
    check("lh_be", acc_be[0], 64'h0);

    // 3: split store and load across words 3/4
    access(64'h1E, 2'b10, 1'b1, 64'hAABBCCDD);
    check("sw_nacc", n_acc, 2);
    check("sw_addr0", acc_addr[0], 64'h3);
    check("sw_be0", acc_be[0], 64'hC0);
    check("sw_wd0", acc_wd[0], 64'hCCDD_0000_0000_0000);
    check("sw_addr1", acc_addr[1], 64'h4);
    check("sw_be1", acc_be[1], 64'h03);
    check("sw_wd1", acc_wd[1], 64'h0000_0000_0000_AABB);
    check("sw_stall", n_stall, 2);
    access(64'h1E, 2'b10, 1'b0, 64'h0);
    check("lw_split_data", rdat, 64'hAABBCCDD);
    check("lw_split_stall", n_stall, 2);
    check("lw_split_vcyc", valid_cyc, 2);

    // 4: out of range
    access(64'h80000, 2'b11, 1'b0, 64'h0);
    check("oor_nacc", n_acc, 0);
    check("oor_err", {63'h0, err_seen}, 64'h1);
    check("oor_errcyc", err_cyc, 1);
    check("oor_stall", n_stall, 1);
    check("oor_novalid", {63'h0, got_valid}, 64'h0);

    // 5: split on last word errors; last byte works
    access(64'h7FFF9, 2'b11, 1'b0, 64'h0);
    check("last_split_err", {63'h0, err_seen}, 64'h1);
    check("last_split_nacc", n_acc, 0);
    access(64'h7FFFF, 2'b00, 1'b1, 64'hA5);
    check("sb_last_addr", acc_addr[0], 64'hFFFF);
    check("sb_last_be", acc_be[0], 64'h80);
    check("sb_last_err", {63'h0, err_seen}, 64'h0);
    access(64'h7FFFF, 2'b00, 1'b0, 64'h0);
    check("lb_last_data", rdat, 64'hA5);
    check("lb_last_err", {63'h0, err_seen}, 64'h0);

    // 6: reset during WAIT1 of a split load, request still held
    req_i     = 1'b1;
    addr_i    = 64'h1E;
    byte_en_i = 2'b10;
    wr_i      = 1'b0;
    wr_data_i = 64'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("w1_valid_pre", {63'h0, rd_valid_o}, 64'h1);
    reset_n = 1'b0;
    #1;
    check("arst_stall", {63'h0, stall_o}, 64'h0);
    check("arst_valid", {63'h0, rd_valid_o}, 64'h0);
    check("arst_en", {63'h0, sram_en_o}, 64'h0);
    check("arst_rdata", rd_data_o, 64'h0);
    req_i = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    access(64'h10, 2'b11, 1'b0, 64'h0);
    check("post_rst_data", rdat, 64'h1122334455667788);
    check("post_rst_stall", n_stall, 1);

    check("stray_outputs", stray, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
